// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder around a single fulladder cell (optional subtract via SERIAL_ADDER_SUB_EN)
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, sum_sh_q, sum_q;
  logic [WIDTH-1:0]   sum_sh_d, b_ld_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q, cout_q, carry_ld_d;
  logic               fa_s, fa_cout, accept, last;
  fulladder fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );
  // Operand load values and serial datapath next-state
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_ld_d     = sub ? ~b : b;
    carry_ld_d = sub ? 1'b1 : cin;
`else
    b_ld_d     = b;
    carry_ld_d = cin;
`endif
    sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
    accept   = start && (state_q == IDLE || state_q == DONE);
    last     = cnt_q == CNT_W'(WIDTH - 1);
  end
  // Control FSM with shift registers, carry flop and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else if (accept) begin
      state_q <= RUN;
      a_sh_q  <= a;
      b_sh_q  <= b_ld_d;
      carry_q <= carry_ld_d;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      sum_sh_q <= sum_sh_d;
      carry_q  <= fa_cout;
      cnt_q    <= cnt_q + 1'b1;
      if (last) begin
        sum_q   <= sum_sh_d;
        cout_q  <= fa_cout;
        state_q <= DONE;
      end
    end else if (state_q == DONE) begin
      state_q <= IDLE;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed table-driven bench for serial_adder_ctrl
module tb_serial_adder_ctrl;
  logic       clk, rst, start, cin, sub_r, busy, done, cout;
  logic [7:0] a, b, sum;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;
  vec_t vt[8];
  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_r),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv);
    @(negedge clk);
    a = av; b = bv; cin = cv; sub_r = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub_r = 1'($urandom);
  endtask
  task automatic wait_done(input int inj, output int lat, output int bc);
    lat = 1; bc = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      if (lat == inj) begin
        start = 1'b1; a = 8'h00; b = 8'h00; cin = 1'b0;
      end else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask
  initial begin
    int lat, bc, seen, gap;
    vt[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vt[5] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1};
    vt[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vt[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_r = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset sum", 32'(sum), 0);
    chk("reset cout", 32'(cout), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      launch(vt[i].a, vt[i].b, vt[i].ci, 1'b0);
      wait_done(-1, lat, bc);
      chk($sformatf("vec%0d latency", i), 32'(lat), 9);
      chk($sformatf("vec%0d busy cycles", i), 32'(bc), 8);
      chk($sformatf("vec%0d sum", i), 32'(sum), 32'(vt[i].s));
      chk($sformatf("vec%0d cout", i), 32'(cout), 32'(vt[i].co));
      @(negedge clk);
      chk($sformatf("vec%0d done one cycle", i), 32'(done), 0);
      chk($sformatf("vec%0d sum held", i), 32'(sum), 32'(vt[i].s));
    end
    launch(8'h5A, 8'h33, 1'b0, 1'b0);
    wait_done(3, lat, bc);
    chk("ignored start latency", 32'(lat), 9);
    chk("ignored start sum", 32'(sum), 32'h8D);
    chk("ignored start cout", 32'(cout), 0);
    @(negedge clk);
    chk("ignored start idle", 32'(busy), 0);
    launch(8'hFF, 8'hFF, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre-abort busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort sum", 32'(sum), 0);
    chk("abort cout", 32'(cout), 0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort no done", 32'(seen), 0);
    @(negedge clk);
    a = 8'h5A; b = 8'h33; rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst beats start busy", 32'(busy), 0);
    @(negedge clk);
    chk("rst beats start stays idle", 32'(busy), 0);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("b2b first done seen", 32'(done), 1);
    chk("b2b first sum", 32'(sum), 3);
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      do begin @(negedge clk); gap++; end while (!done && gap < 20);
      chk($sformatf("b2b period %0d", k), 32'(gap), 9);
      chk($sformatf("b2b sum %0d", k), 32'(sum), 3);
      chk($sformatf("b2b cout %0d", k), 32'(cout), 0);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b ends idle", 32'({busy, done}), 0);
`ifdef SERIAL_ADDER_SUB_EN
    launch(8'h10, 8'h20, 1'b0, 1'b1);
    wait_done(-1, lat, bc);
    chk("sub 10-20 sum", 32'(sum), 32'hF0);
    chk("sub 10-20 cout", 32'(cout), 0);
    launch(8'h20, 8'h10, 1'b1, 1'b1);
    wait_done(-1, lat, bc);
    chk("sub 20-10 sum", 32'(sum), 32'h10);
    chk("sub 20-10 cout", 32'(cout), 1);
    launch(8'h20, 8'h10, 1'b1, 1'b0);
    wait_done(-1, lat, bc);
    chk("sub=0 add sum", 32'(sum), 32'h31);
    chk("sub=0 add cout", 32'(cout), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
